// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - color codes, rainbow order and index helpers for the LED sequencer
package led_pkg;

  localparam logic [2:0] C_WHITE   = 3'b000;
  localparam logic [2:0] C_MAGENTA = 3'b001;
  localparam logic [2:0] C_YELLOW  = 3'b010;
  localparam logic [2:0] C_RED     = 3'b011;
  localparam logic [2:0] C_CYAN    = 3'b100;
  localparam logic [2:0] C_BLUE    = 3'b101;
  localparam logic [2:0] C_GREEN   = 3'b110;
  localparam logic [2:0] C_OFF     = 3'b111;

  localparam int N_COLORS = 6;
  localparam int N_SHIFT  = 32;

  localparam logic [2:0] RAINBOW [N_COLORS] =
    '{C_RED, C_YELLOW, C_GREEN, C_CYAN, C_BLUE, C_MAGENTA};

  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic rev);
    if (rev)
      return (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    else
      return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  // Out-of-range indices map to dark rather than indexing past the table.
  function automatic logic [2:0] rainbow_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RAINBOW[0];
      3'd1:    return RAINBOW[1];
      3'd2:    return RAINBOW[2];
      3'd3:    return RAINBOW[3];
      3'd4:    return RAINBOW[4];
      3'd5:    return RAINBOW[5];
      default: return C_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - free-running PWM counter blending current and target color into registered led
module led_pwm
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] cur,
  input  logic [2:0] tgt,
  input  logic [4:0] shift_cnt,
  output logic [2:0] led
);

  logic [4:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      led     <= C_OFF;
    end else begin
      if (en)
        pwm_cnt <= pwm_cnt + 5'd1;
      if (!en)
        led <= C_OFF;
      else if (pwm_cnt < shift_cnt)
        led <= tgt;
      else
        led <= cur;
    end
  end

endmodule

// File: rtl/led_color_sequencer.sv
// rtl/led_color_sequencer.sv - rainbow fade sequencer: run/pause FSM, prescaler, shift and color index
module led_color_sequencer
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 24_000_000,
  parameter int CYCLE_S = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       dir,
  output logic [2:0] led,
  output logic [2:0] color_idx,
  output logic       cycle_done
);

  localparam int SHIFT_TICKS = CLK_HZ * CYCLE_S / (6 * 32);
  localparam int PW = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SHIFT_TICKS - 1);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic [1:0]    state, state_n;
  logic [PW-1:0] prescaler, prescaler_n;
  logic [4:0]    shift_cnt;
  logic          dir_q;
  logic          adv;
  logic          wrap;

  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    adv         = 1'b0;
    case (state)
      ST_OFF: begin
        if (run) begin
          state_n = ST_RUN;
        end else if (step) begin
          state_n = ST_PAUSE;
          adv     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_n = ST_PAUSE;
        end else if (prescaler == PRE_LAST) begin
          prescaler_n = '0;
          adv         = 1'b1;
        end else begin
          prescaler_n = prescaler + PW'(1);
        end
      end
      ST_PAUSE: begin
        // run has priority: a coincident step is dropped
        if (run) begin
          state_n = ST_RUN;
        end else if (step) begin
          prescaler_n = '0;
          adv         = 1'b1;
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  assign wrap = adv && (shift_cnt == 5'(N_SHIFT - 1));

  // dir is only taken at a color boundary so a reversal never jumps mid-fade.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      prescaler  <= '0;
      shift_cnt  <= '0;
      color_idx  <= '0;
      dir_q      <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_n;
      prescaler  <= prescaler_n;
      cycle_done <= 1'b0;
      if (state == ST_OFF && state_n != ST_OFF)
        dir_q <= dir;
      if (adv)
        shift_cnt <= shift_cnt + 5'd1;
      if (wrap) begin
        color_idx  <= next_idx(color_idx, dir_q);
        dir_q      <= dir;
        cycle_done <= dir_q ? (color_idx == 3'd0) : (color_idx == 3'd5);
      end
    end
  end

  led_pwm u_pwm (
    .clk       (clk),
    .rst       (rst),
    .en        (state != ST_OFF),
    .cur       (rainbow_color(color_idx)),
    .tgt       (rainbow_color(next_idx(color_idx, dir_q))),
    .shift_cnt (shift_cnt),
    .led       (led)
  );

endmodule

// File: tb/tb_led_color_sequencer.sv
// tb/tb_led_color_sequencer.sv - directed self-checking bench for led_color_sequencer
module tb_led_color_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, step, dir;
  logic [2:0] led, color_idx;
  logic       cycle_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_color_sequencer #(.CLK_HZ(1920), .CYCLE_S(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .dir        (dir),
    .led        (led),
    .color_idx  (color_idx),
    .cycle_done (cycle_done)
  );

  typedef struct {
    logic       rst;
    logic       run;
    logic       step;
    logic       dir;
    logic [2:0] led;
    logic [2:0] idx;
    logic       done;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    step = 1'b0;
    dir  = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  initial begin
    int ndone, done_at, nyel;

    rst = 1'b1; run = 1'b0; step = 1'b0; dir = 1'b0;

    //            rst run stp dir  led     idx  done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst  = vecs[i].rst;
      run  = vecs[i].run;
      step = vecs[i].step;
      dir  = vecs[i].dir;
      tick();
      check($sformatf("vec%0d_led", i),  led,        vecs[i].led);
      check($sformatf("vec%0d_idx", i),  color_idx,  vecs[i].idx);
      check($sformatf("vec%0d_done", i), cycle_done, vecs[i].done);
    end

    // Idle after reset: dark, index 0, no wrap pulse.
    do_reset();
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("idle_led", led, 3'b111);
      if (cycle_done) ndone++;
    end
    check("idle_idx", color_idx, 3'd0);
    check("idle_done_cnt", ndone, 0);

    // Full forward cycle: one shift every 10 cycles, one color every 320.
    do_reset();
    run = 1'b1;
    tick();
    ndone = 0;
    done_at = -1;
    for (int k = 1; k <= 1920; k++) begin
      tick();
      if (k <= 10)  check("first_shift_red", led, 3'b011);
      if (k == 319) check("idx_before_320", color_idx, 3'd0);
      if (k == 320) check("idx_at_320", color_idx, 3'd1);
      if (cycle_done) begin
        ndone++;
        done_at = k;
      end
    end
    check("full_cycle_done_cnt", ndone, 1);
    check("full_cycle_done_at", done_at, 1920);
    check("full_cycle_idx", color_idx, 3'd0);

    // Pause with shift_cnt=5, prescaler=3; then step through the wrap.
    do_reset();
    run = 1'b1;
    tick();
    repeat (53) tick();
    check("pause_shift5", dut.shift_cnt, 5);
    check("pause_pre3", dut.prescaler, 3);
    run = 1'b0;
    tick();
    nyel = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (led == 3'b010) nyel++;
    end
    check("duty_5_of_32", nyel, 5);
    check("pause_pre_frozen", dut.prescaler, 3);
    for (int s = 1; s <= 27; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (3) tick();
      check("step_pre_cleared", dut.prescaler, 0);
      if (s == 26) begin
        check("step26_shift", dut.shift_cnt, 31);
        check("step26_idx", color_idx, 3'd0);
      end
    end
    check("step27_shift", dut.shift_cnt, 0);
    check("step27_idx", color_idx, 3'd1);
    run  = 1'b1;
    step = 1'b1;
    tick();
    check("run_beats_step_shift", dut.shift_cnt, 0);
    check("run_beats_step_pre", dut.prescaler, 0);
    tick();
    step = 1'b0;
    check("step_in_run_shift", dut.shift_cnt, 0);
    check("step_in_run_pre", dut.prescaler, 1);

    // Reverse requested mid-fade: forward fade completes, then 1->0->5.
    do_reset();
    run = 1'b1;
    tick();
    repeat (100) tick();
    dir = 1'b1;
    ndone = 0;
    done_at = -1;
    for (int k = 101; k <= 960; k++) begin
      tick();
      if (k == 319) check("rev_idx_319", color_idx, 3'd0);
      if (k == 320) check("rev_idx_320", color_idx, 3'd1);
      if (k == 639) check("rev_idx_639", color_idx, 3'd1);
      if (k == 640) check("rev_idx_640", color_idx, 3'd0);
      if (k == 960) check("rev_idx_960", color_idx, 3'd5);
      if (cycle_done) begin
        ndone++;
        done_at = k;
      end
    end
    check("rev_done_cnt", ndone, 1);
    check("rev_done_at", done_at, 960);

    // Reset mid-fade discards everything; run restarts from RED.
    do_reset();
    run = 1'b1;
    tick();
    repeat (1130) tick();
    check("mid_idx3", color_idx, 3'd3);
    check("mid_shift17", dut.shift_cnt, 17);
    rst  = 1'b1;
    step = 1'b1;
    tick();
    check("rst_led", led, 3'b111);
    check("rst_idx", color_idx, 3'd0);
    check("rst_shift", dut.shift_cnt, 0);
    check("rst_pre", dut.prescaler, 0);
    check("rst_pwm", dut.u_pwm.pwm_cnt, 0);
    check("rst_done", cycle_done, 1'b0);
    rst  = 1'b0;
    step = 1'b0;
    tick();
    tick();
    check("restart_led_red", led, 3'b011);
    check("restart_idx", color_idx, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
